// File: rtl/cm0_soc_pkg.sv
// Shared constants for the cortex_m0_soc UART message beacon.
package cm0_soc_pkg;

  localparam int unsigned FRAME_BITS      = 10;
  localparam int unsigned DEFAULT_CLK_DIV = 16;
  localparam int unsigned ROM_DEPTH       = 16;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned DIV_W           = 16;
  localparam int unsigned BIT_W           = 4;

  // "Hello CortexM0!\n", element 0 = 'H', element 15 = '\n'
  localparam logic [ROM_DEPTH-1:0][7:0] MSG_ROM = {
    8'h0A, 8'h21, 8'h30, 8'h4D, 8'h78, 8'h65, 8'h74, 8'h72,
    8'h6F, 8'h43, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
  };

endpackage

// File: rtl/cm0_uart_tx.sv
// 8N1 UART transmitter: divider, bit counter and shift register.
// A start request seen at the end of a stop bit chains the next frame with no idle gap.
module cm0_uart_tx
  import cm0_soc_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [8:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;

  // Last cycle of the stop bit
  assign done_c = (state_q == ST_FRAME) && (bit_q == BIT_LAST) && (div_q == DIV_LAST);

  // Next-state: load a frame, advance the divider, or step to the next bit
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FRAME;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
          shift_d = {1'b1, data};
          bit_d   = '0;
          div_d   = '0;
        end
      end
      ST_FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            if (start) begin
              txd_d   = 1'b0;
              shift_d = {1'b1, data};
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              txd_d   = 1'b1;
              bit_d   = '0;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transmitter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: rtl/cortex_m0_soc.sv
// Continuous UART beacon sending the message ROM back-to-back.
// Optional macro CM0_SOC_LED_EN: when defined, LED counts completed frames;
// otherwise LED is tied to zero.
module cortex_m0_soc
  import cm0_soc_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned MSG_LEN = ROM_DEPTH
) (
  input  logic       clk,
  input  logic       RSTn,
  output logic       TXD,
  output logic       tx_busy,
  output logic [7:0] LED
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  logic             rst;
  logic             done_c;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt_c;
  logic [7:0]       data_c;

  // The reset pin is active high despite its name
  assign rst = RSTn;

  // At the end of a frame the transmitter loads the following byte on the same edge
  always_comb begin
    idx_nxt_c = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    data_c    = done_c ? MSG_ROM[idx_nxt_c] : MSG_ROM[idx_q];
  end

  // Byte index of the frame currently on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else if (done_c) idx_q <= idx_nxt_c;
  end

  cm0_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (1'b1),
    .data   (data_c),
    .txd    (TXD),
    .busy   (tx_busy),
    .done_c (done_c)
  );

`ifdef CM0_SOC_LED_EN
  logic [7:0] led_q;

  // Completed-frame counter, wraps at 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else if (done_c) led_q <= led_q + 8'(1);
  end

  assign LED = led_q;
`else
  assign LED = 8'h00;
`endif

endmodule

// File: tb/tb_cortex_m0_soc.sv
// Directed bench: instance A (CLK_DIV=16, MSG_LEN=16), instance B (CLK_DIV=2, MSG_LEN=4).
module tb_cortex_m0_soc;

  logic       clk;
  logic       rst_a, rst_b;
  logic       txd_a, busy_a, txd_b, busy_b;
  logic [7:0] led_a, led_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] msg [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h43, 8'h6F,
                           8'h72, 8'h74, 8'h65, 8'h78, 8'h4D, 8'h30, 8'h21, 8'h0A};

  cortex_m0_soc #(.CLK_DIV(16), .MSG_LEN(16)) u_dut_a (
    .clk(clk), .RSTn(rst_a), .TXD(txd_a), .tx_busy(busy_a), .LED(led_a)
  );

  cortex_m0_soc #(.CLK_DIV(2), .MSG_LEN(4)) u_dut_b (
    .clk(clk), .RSTn(rst_b), .TXD(txd_b), .tx_busy(busy_b), .LED(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] led_exp(input int n);
`ifdef CM0_SOC_LED_EN
    return 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  // Sample one frame at negedges; clean=0 on any intra-bit change or busy drop
  task automatic rx_frame(input bit sel, input int div, output logic [9:0] bits, output logic clean);
    logic tx, bz;
    clean = 1'b1;
    bits  = '0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        tx = sel ? txd_b : txd_a;
        bz = sel ? busy_b : busy_a;
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) clean = 1'b0;
        if (bz !== 1'b1) clean = 1'b0;
      end
    end
  endtask

  // Check LED/TXD just after the frame-start edge, then decode and check the frame
  task automatic frame_check(input bit sel, input int div, input int n, input logic [7:0] exp_byte);
    logic [9:0] bits;
    logic       clean;
    @(posedge clk);
    #1;
    check($sformatf("%s.f%0d.led", sel ? "b" : "a", n), sel ? led_b : led_a, led_exp(n));
    rx_frame(sel, div, bits, clean);
    check($sformatf("%s.f%0d.bits", sel ? "b" : "a", n), 32'(bits), 32'({1'b1, exp_byte, 1'b0}));
    check($sformatf("%s.f%0d.clean", sel ? "b" : "a", n), 32'(clean), 32'd1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    check("rst.txd", txd_a, 1'b1);
    check("rst.busy", busy_a, 1'b0);
    check("rst.led", led_a, 8'h00);

    // Full message plus wrap to 'H'; frame 0 bits = 10'h290 for 0x48
    @(negedge clk);
    rst_a = 1'b0;
    for (int n = 0; n < 17; n++) frame_check(1'b0, 16, n, msg[n % 16]);

    // Mid-frame reset during data bit 3 of byte 5 (' ' = 0x20, bit 3 = 0)
    @(negedge clk);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    for (int n = 0; n < 5; n++) frame_check(1'b0, 16, n, msg[n]);
    @(posedge clk);
    #1;
    check("mid.led_pre", led_a, led_exp(5));
    repeat (70) @(negedge clk);
    #1;
    check("mid.txd_pre", txd_a, 1'b0);
    rst_a = 1'b1;
    #1;
    check("mid.txd", txd_a, 1'b1);
    check("mid.busy", busy_a, 1'b0);
    check("mid.led", led_a, 8'h00);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    frame_check(1'b0, 16, 0, 8'h48);

    // CLK_DIV=2, MSG_LEN=4: "Hell" repeats, LED wraps after 256 frames
    @(negedge clk);
    rst_b = 1'b0;
    for (int n = 0; n < 256; n++) frame_check(1'b1, 2, n, msg[n % 4]);
    @(posedge clk);
    #1;
    check("b.led_wrap", led_b, 8'h00);
    check("b.busy_end", busy_b, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cortex_m0_soc.md
CORTEX_M0_SOC -- requirements
Module: cortex_m0_soc

Interface
REQ-001 The block SHALL provide parameter CLK_DIV, default 16, giving clock cycles per UART bit; legal values 2..65535.
REQ-002 The block SHALL provide parameter MSG_LEN, default 16, giving the number of message bytes sent before the index wraps; legal values 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit: asynchronous, active-high reset. Despite its name, logic 1 resets the block.
REQ-005 The block SHALL have port TXD, output, 1 bit: UART serial output, 8N1, LSB first, idle high.
REQ-006 The block SHALL have port tx_busy, output, 1 bit: high while a frame is on TXD.
REQ-007 The block SHALL have port LED, output, 8 bits: count of completed frames, modulo 256.

Function
REQ-008 The block SHALL hold a 16-byte message ROM containing ASCII "Hello CortexM0!\n", with byte 0 = 0x48 'H' and byte 15 = 0x0A.
REQ-009 The block SHALL start a frame on the first rising clk edge after RSTn deasserts, driving TXD low as the start bit.
REQ-010 Each frame SHALL be 10 bits: start bit 0, data bits d0..d7, then stop bit 1. Each bit SHALL be held exactly CLK_DIV cycles, so a frame lasts 10*CLK_DIV cycles.
REQ-011 The next start bit SHALL begin on the cycle immediately after the last stop-bit cycle, with no idle gap.
REQ-012 The byte index SHALL advance 0,1,...,MSG_LEN-1, then wrap to 0 and repeat indefinitely.
REQ-013 LED SHALL increment by 1 on the cycle in which a stop bit completes, and SHALL wrap from 255 to 0.
REQ-014 tx_busy SHALL be 1 during every frame cycle. It is 0 only while reset is asserted.
REQ-015 The bit counter SHALL be 4 bits and the divider counter 16 bits. The divider counts 0..CLK_DIV-1 and wraps.

Reset
REQ-016 While RSTn=1, the following SHALL be forced immediately, without waiting for clk: TXD=1, tx_busy=0, LED=0x00, byte index=0, bit counter=0, divider=0.
REQ-017 If reset asserts mid-frame, the partial frame SHALL be abandoned with no LED increment. After deassertion, transmission restarts at byte 0.

Configuration
REQ-018 With macro CM0_SOC_LED_EN defined, the block SHALL contain the LED frame counter as specified in REQ-013.
REQ-019 With CM0_SOC_LED_EN undefined, the LED counter SHALL be omitted, LED SHALL be tied to 0x00, and all other behaviour SHALL be unchanged.

Structure
REQ-020 Shared package cm0_soc_pkg SHALL hold:
- the message ROM constant array (16 x 8 bits);
- FRAME_BITS=10;
- DEFAULT_CLK_DIV=16.
REQ-021 Sub-module cm0_uart_tx SHALL own the divider, bit counter and shift register. Its handshake SHALL be:
- start is sampled when not busy;
- data[7:0] is loaded;
- a done pulse is asserted for 1 cycle at the end of the stop bit.
REQ-022 The top level SHALL own the ROM index sequencing and the LED counter.

Verification
REQ-023 Reset release with CLK_DIV=16: RSTn 1->0, then on the first edge TXD=0; TXD stays 0 for 16 cycles; the next 128 cycles carry 0x48 as bits 0,0,0,1,0,0,1,0 (LSB first); then 16 cycles of TXD=1.
REQ-024 Full message with CLK_DIV=16: decode 16 consecutive frames and expect the bytes of "Hello CortexM0!\n" in order, LED=16 after the 16th stop bit, and the 17th frame is 0x48 again.
REQ-025 Back-to-back frames: the start bit of frame n+1 occurs exactly 160 cycles after the start bit of frame n, and tx_busy stays 1 throughout.
REQ-026 Mid-frame reset: assert RSTn during data bit 3 of byte 5. Expect TXD=1, tx_busy=0 and LED=0 without waiting for a clk edge. After release, the next decoded byte is 0x48.
REQ-027 Counter wrap with CLK_DIV=2: run 256 frames and expect LED to return to 0x00. Built without CM0_SOC_LED_EN, LED stays 0x00 throughout.
REQ-028 MSG_LEN=4: the decoded stream repeats "Hell".
